// File: rtl/window_scan_addr_gen.sv
// Row-major address generator for a rectangular search window.
// Emits (x, y, addr = x*frame_width + y) beats over a valid/ready handshake,
// then pulses done for one cycle before returning to IDLE.
module window_scan_addr_gen #(
   parameter int COORD_W = 8,
   parameter int ADDR_W  = 14
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               start,
   input  logic [COORD_W-1:0] base_x,
   input  logic [COORD_W-1:0] base_y,
   input  logic [COORD_W-1:0] win_rows,
   input  logic [COORD_W-1:0] win_cols,
   input  logic [COORD_W-1:0] frame_width,
   input  logic               ready,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  addr,
   output logic               valid,
   output logic               last,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COORD_W-1:0] bx_q, bx_d;
   logic [COORD_W-1:0] by_q, by_d;
   logic [COORD_W-1:0] rows_q, rows_d;
   logic [COORD_W-1:0] cols_q, cols_d;
   logic [COORD_W-1:0] fw_q, fw_d;

   // End-of-row / end-of-window positions wrap mod 2^COORD_W like the coordinates.
   logic [COORD_W-1:0] last_col;
   logic [COORD_W-1:0] last_row;
   logic               at_last_col;
   logic               at_last_row;

   assign last_col    = by_q + cols_q - COORD_W'(1);
   assign last_row    = bx_q + rows_q - COORD_W'(1);
   assign at_last_col = (y_q == last_col);
   assign at_last_row = (x_q == last_row);

   // State and datapath registers; reset abandons any scan without a done pulse.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         rows_q  <= '0;
         cols_q  <= '0;
         fw_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
         fw_q    <= fw_d;
      end
   end

   // Next-state logic: launch/latch in IDLE, advance row-major on each transfer.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      bx_d    = bx_q;
      by_d    = by_q;
      rows_d  = rows_q;
      cols_d  = cols_q;
      fw_d    = fw_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((win_rows != '0) && (win_cols != '0)) begin
                  bx_d    = base_x;
                  by_d    = base_y;
                  rows_d  = win_rows;
                  cols_d  = win_cols;
                  fw_d    = frame_width;
                  x_d     = base_x;
                  y_d     = base_y;
                  state_d = S_SCAN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SCAN: begin
            if (ready) begin
               if (!at_last_col) begin
                  y_d = y_q + COORD_W'(1);
               end else begin
                  y_d = by_q;
                  if (at_last_row) begin
                     state_d = S_DONE;
                  end else begin
                     x_d = x_q + COORD_W'(1);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign x     = x_q;
   assign y     = y_q;
   assign valid = (state_q == S_SCAN);
   assign last  = valid & at_last_col & at_last_row;
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);

   // Evaluating the multiply-add directly at ADDR_W bits yields exactly the
   // full-width result reduced mod 2^ADDR_W, without carrying unused high bits.
   assign addr = ADDR_W'(x_q) * ADDR_W'(fw_q) + ADDR_W'(y_q);

endmodule

// File: tb/tb_window_scan_addr_gen.sv
// Randomised and directed bench for window_scan_addr_gen with an
// expected-beat queue built from nested row/column loops.
module tb_window_scan_addr_gen;

   localparam int COORD_W = 8;
   localparam int ADDR_W  = 14;

   logic               Clk;
   logic               Rst;
   logic               start;
   logic [COORD_W-1:0] base_x, base_y, win_rows, win_cols, frame_width;
   logic               ready;
   logic [COORD_W-1:0] x, y;
   logic [ADDR_W-1:0]  addr;
   logic               valid, last, busy, done;

   window_scan_addr_gen #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Rst(Rst), .start(start),
      .base_x(base_x), .base_y(base_y), .win_rows(win_rows), .win_cols(win_cols),
      .frame_width(frame_width), .ready(ready),
      .x(x), .y(y), .addr(addr), .valid(valid), .last(last), .busy(busy), .done(done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct {
      int x;
      int y;
      int addr;
      bit last;
   } beat_t;

   beat_t mq[$];
   bit    m_done = 1'b0;
   bit    m_was_busy;
   bit    m_nd;

   int log_addr[$];
   int log_last[$];
   int log_x[$];
   int log_y[$];
   int done_cnt  = 0;
   int valid_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Reference: a started scan is the full list of beats in row-major order.
   task automatic model_fill(input int bx, input int by, input int r, input int c, input int fw);
      for (int i = 0; i < r; i++) begin
         for (int j = 0; j < c; j++) begin
            beat_t b;
            b.x    = (bx + i) % 256;
            b.y    = (by + j) % 256;
            b.addr = (b.x * fw + b.y) % 16384;
            b.last = (i == r - 1) && (j == c - 1);
            mq.push_back(b);
         end
      end
   endtask

   // Model update at each rising edge from the inputs held there.
   always @(posedge Clk) begin
      if (Rst) begin
         mq.delete();
         m_done = 1'b0;
      end else begin
         m_was_busy = (mq.size() != 0) || m_done;
         m_nd = 1'b0;
         if (mq.size() != 0 && ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_nd = 1'b1;
         end
         if (!m_was_busy && start) begin
            if (win_rows == 0 || win_cols == 0) m_nd = 1'b1;
            else model_fill(base_x, base_y, win_rows, win_cols, frame_width);
         end
         m_done = m_nd;
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("valid", valid, mq.size() != 0);
         chk("busy", busy, (mq.size() != 0) || m_done);
         chk("done", done, m_done);
         if (mq.size() != 0) begin
            chk("x", x, mq[0].x);
            chk("y", y, mq[0].y);
            chk("addr", addr, mq[0].addr);
            chk("last", last, mq[0].last);
         end else begin
            chk("last_idle", last, 0);
         end
         if (valid && ready) begin
            log_addr.push_back(addr);
            log_last.push_back(last);
            log_x.push_back(x);
            log_y.push_back(y);
         end
         if (done)  done_cnt++;
         if (valid) valid_cnt++;
      end
   end

   task automatic clear_logs();
      log_addr.delete(); log_last.delete(); log_x.delete(); log_y.delete();
      done_cnt = 0;
      valid_cnt = 0;
   endtask

   task automatic set_win(input int bx, input int by, input int r, input int c, input int fw);
      base_x = bx; base_y = by; win_rows = r; win_cols = c; frame_width = fw;
   endtask

   task automatic wait_idle(input string name, input bit rand_ready, input bit rand_start);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         if (rand_ready) ready = ($urandom % 10) < 7;
         if (rand_start) begin
            start = ($urandom % 8) == 0;
            base_x = $urandom; base_y = $urandom;
            win_rows = $urandom_range(0, 5); win_cols = $urandom_range(0, 5);
         end
         @(posedge Clk); #1;
         n++;
      end
      start = 1'b0;
      ready = 1'b1;
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=busy required=idle", name);
      end
   endtask

   task automatic run_scan(input string name, input int bx, input int by, input int r,
                           input int c, input int fw, input bit rnd);
      set_win(bx, by, r, c, fw);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      wait_idle(name, rnd, rnd);
      $display("scan %s base=(%0d,%0d) win=%0dx%0d fw=%0d beats=%0d dones=%0d",
               name, bx, by, r, c, fw, log_addr.size(), done_cnt);
   endtask

   int exp1[6] = '{66, 67, 68, 130, 131, 132};
   int n;

   initial begin
      Rst = 1'b1; start = 1'b0; ready = 1'b1;
      set_win(0, 0, 0, 0, 0);
      @(posedge Clk); #1;
      chk_en = 1'b1;
      @(posedge Clk); #1;
      chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      Rst = 1'b0;
      @(posedge Clk); #1;

      // Basic scan
      clear_logs();
      run_scan("basic", 1, 2, 2, 3, 64, 0);
      chk("basic_count", log_addr.size(), 6);
      if (log_addr.size() == 6)
         for (int i = 0; i < 6; i++) begin
            chk("basic_addr", log_addr[i], exp1[i]);
            chk("basic_last", log_last[i], (i == 5));
         end
      chk("basic_done", done_cnt, 1);

      // Backpressure while addr 67 is presented
      clear_logs();
      set_win(1, 2, 2, 3, 64);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      @(posedge Clk); #1;
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_addr", addr, 67); chk("bp_x", x, 1); chk("bp_y", y, 3);
         if (i < 3) begin @(posedge Clk); #1; end
      end
      ready = 1'b1;
      wait_idle("bp", 0, 0);
      chk("bp_count", log_addr.size(), 6);
      if (log_addr.size() == 6)
         for (int i = 0; i < 6; i++) chk("bp_seq", log_addr[i], exp1[i]);
      $display("scan bp beats=%0d dones=%0d", log_addr.size(), done_cnt);

      // Zero-size window
      clear_logs();
      run_scan("zero", 3, 3, 0, 5, 64, 0);
      chk("zero_valid", valid_cnt, 0);
      chk("zero_done", done_cnt, 1);

      // Wrap / truncation
      clear_logs();
      run_scan("wrap", 255, 255, 1, 1, 64, 0);
      chk("wrap_count", log_addr.size(), 1);
      if (log_addr.size() == 1) begin
         chk("wrap_addr", log_addr[0], 191); chk("wrap_last", log_last[0], 1);
         chk("wrap_x", log_x[0], 255); chk("wrap_y", log_y[0], 255);
      end

      // Start ignored while busy
      clear_logs();
      set_win(0, 0, 3, 3, 10);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge Clk); #1; end
      set_win(50, 50, 2, 2, 7);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      wait_idle("ignore", 0, 0);
      chk("ign_count", log_addr.size(), 9);
      if (log_addr.size() == 9) begin
         chk("ign_first", log_addr[0], 0); chk("ign_final", log_addr[8], 22);
      end
      chk("ign_done", done_cnt, 1);
      $display("scan ignore beats=%0d dones=%0d", log_addr.size(), done_cnt);

      // Reset during third beat of a 4x4 scan
      clear_logs();
      set_win(0, 0, 4, 4, 16);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      n = 0;
      while (log_addr.size() < 2 && n < 100) begin @(posedge Clk); #1; n++; end
      chk("rms_reach", log_addr.size(), 2);
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      chk("rms_valid", valid, 0); chk("rms_busy", busy, 0);
      chk("rms_x", x, 0); chk("rms_y", y, 0);
      repeat (5) begin @(posedge Clk); #1; end
      chk("rms_nodone", done_cnt, 0);
      $display("scan reset_mid beats=%0d dones=%0d", log_addr.size(), done_cnt);
      clear_logs();
      run_scan("after_rst", 2, 3, 4, 4, 16, 0);
      chk("ar_count", log_addr.size(), 16);
      if (log_addr.size() == 16) begin
         chk("ar_first", log_addr[0], 35); chk("ar_final", log_addr[15], 86);
      end
      chk("ar_done", done_cnt, 1);

      // Randomised scans with random backpressure and stray starts
      for (int k = 0; k < 40; k++) begin
         clear_logs();
         run_scan("rand", $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 255), 1);
         chk("rand_done", done_cnt, 1);
         @(posedge Clk); #1;
      end

      repeat (2) @(posedge Clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/window_scan_addr_gen.md
Name: window_scan_addr_gen

Overview:
- Sequential address generator that sits directly upstream of the 2D-to-1D mapper stage in the frame-memory path.
- Walks a rectangular search window (win_rows x win_cols) starting at (base_x, base_y) in row-major order.
- Each beat presents an (x, y) coordinate pair and the linear frame address addr = x*frame_width + y, using the same convention as the mapper: x = row, y = column.
- Uses a valid/ready handshake so the downstream memory-read stage can stall it.

Parameters:
- COORD_W, 8, width of x, y, base and dimension inputs
- ADDR_W, 14, width of linear address output; result is truncated mod 2^ADDR_W

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- start  in  1  launch a scan; sampled only in IDLE
- base_x  in  COORD_W  window top row
- base_y  in  COORD_W  window left column
- win_rows  in  COORD_W  number of rows in window
- win_cols  in  COORD_W  number of columns in window
- frame_width  in  COORD_W  frame row pitch (words per row)
- ready  in  1  downstream accepts current beat
- x  out  COORD_W  current row coordinate
- y  out  COORD_W  current column coordinate
- addr  out  ADDR_W  x*frame_width + y for current x, y
- valid  out  1  x/y/addr hold a beat
- last  out  1  current beat is final element of window (qualified by valid)
- busy  out  1  scan in progress (state != IDLE)
- done  out  1  one-cycle pulse after final beat is accepted, or after a zero-size start

Behaviour:
- Reset (Rst=1 at a rising edge): state=IDLE; x=0, y=0, valid=0, last=0, busy=0, done=0. Reset overrides any in-flight scan; no further beats are produced.
- Handshake: a beat transfers when valid & ready are both high at a rising edge. While valid=1 & ready=0, x, y, addr and last are held stable.
- State IDLE:
  - start=1 with win_rows!=0 and win_cols!=0: latch base_x, base_y, win_rows, win_cols and frame_width. Set x=base_x, y=base_y, valid=1, and go to SCAN.
  - start=1 with win_rows==0 or win_cols==0: go to DONE with no beats produced.
- State SCAN, on each transfer:
  - If y is not the last column (y != base_y+win_cols-1): y = y+1.
  - Else: y = base_y. Then if x is the last row (x == base_x+win_rows-1), valid=0 and go to DONE; otherwise x = x+1.
- State DONE: done=1 for exactly one cycle, then go to IDLE. busy is high in SCAN and DONE.
- start is ignored outside IDLE. Input changes after the latch have no effect on the current scan.
- last = valid & (y == base_y+win_cols-1) & (x == base_x+win_rows-1), using latched values.
- Arithmetic and widths:
  - End-of-row and end-of-window compares use COORD_W-bit modular arithmetic, so coordinates wrap mod 2^COORD_W.
  - addr is computed at full product width (2*COORD_W), then truncated to ADDR_W bits.
  - addr is combinational from the registered x, y and latched frame_width, so it is always consistent with x and y in the same cycle.
- Throughput and latency:
  - With ready held high: first beat valid in the cycle after start is sampled, one beat per cycle.
  - valid is high for exactly win_rows*win_cols cycles, and done pulses in the cycle after the last transfer.
- Back-to-back scans: start may be asserted in the cycle done is high, but it is only sampled once the FSM is back in IDLE (the following cycle).

Test Plan:
- Basic scan, ready=1: base (1,2), win 2x3, frame_width=64, start pulse -> six beats with addr 66, 67, 68, 130, 131, 132; last only on 132; done pulses the next cycle; busy then falls.
- Backpressure: same window, ready=0 for 3 cycles while the beat with addr=67 is presented -> x=1, y=3, addr=67 held stable for 3 cycles. Sequence unchanged after ready returns; total beats still 6.
- Zero-size window: win_rows=0, win_cols=5, start -> valid never asserts; done pulses once; returns to IDLE.
- Wrap/truncation: base (255,255), win 1x1, frame_width=64 -> single beat x=255, y=255, addr=(255*64+255) mod 16384 = 191, last=1.
- Start ignored while busy: start re-pulsed mid-scan with different base -> original sequence completes unchanged; only one done pulse.
- Reset mid-scan: Rst=1 for one cycle during the 3rd beat of a 4x4 scan -> next cycle valid=0, busy=0, x=0, y=0, and no done pulse. A new start then runs a full 16-beat scan.
